bus_interface: RTL and testbench

Downstream bus stage for the memory controller. Accepts one read or write request at a time and runs it as a Wishbone-classic-style cycle on the shared memory bus. Returns read data and a one-cycle completion strobe, and drives `bus_full` back to the controller while a transaction is in flight. A watchdog aborts any cycle that the slave never acknowledges.

---
 rtl/bus_pkg.sv | 23 ++
 rtl/bus_timeout_counter.sv | 28 ++
 rtl/bus_interface.sv | 129 ++++++++++++
 tb/tb_bus_interface.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and constants for the memory-bus stage: FSM states, bus widths
// and the latched request record.
package bus_pkg;

  localparam int BUS_TIMEOUT_DEFAULT = 16;
  localparam int DATA_W              = 32;
  localparam int ADDR_W              = 32;
  localparam int SEL_W               = 4;

  typedef enum logic [1:0] {
    B_IDLE = 2'd0,
    B_REQ  = 2'd1,
    B_RESP = 2'd2
  } bus_state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] dat;
    logic [SEL_W-1:0]  sel;
  } bus_req_t;

endpackage

// File: rtl/bus_timeout_counter.sv
// Watchdog counter for the bus request phase; flags the last allowed cycle
// so the FSM can abort a cycle the slave never acknowledges.
module bus_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = en && (count == LAST);

endmodule

// File: rtl/bus_interface.sv
// Single-outstanding Wishbone-classic master: latches one upstream request,
// runs it on the memory bus, and reports completion/timeout with a done strobe.
module bus_interface
  import bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = BUS_TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [SEL_W-1:0]  req_sel,
  output logic              bus_full,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              error,
  output logic              mem_cyc,
  output logic              mem_stb,
  output logic              mem_we,
  output logic [SEL_W-1:0]  mem_sel,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_dat_o,
  input  logic [DATA_W-1:0] mem_dat_i,
  input  logic              mem_ack
);

  bus_state_t state, state_next;
  bus_req_t   req_q;

  logic take_req;
  logic ack_hit;
  logic timed_out;
  logic cnt_en;
  logic cnt_clr;
  logic cnt_expired;

  // Counter runs only in the request phase; an ack or expiry resets it early.
  assign cnt_en  = (state == B_REQ);
  assign cnt_clr = (state != B_REQ) || mem_ack || cnt_expired;

  bus_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .en     (cnt_en),
    .clr    (cnt_clr),
    .expired(cnt_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= B_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    take_req   = 1'b0;
    ack_hit    = 1'b0;
    timed_out  = 1'b0;
    case (state)
      B_IDLE: begin
        if (req_read || req_write) begin
          take_req   = 1'b1;
          state_next = B_REQ;
        end
      end
      B_REQ: begin
        // Ack takes priority over a simultaneous expiry.
        if (mem_ack) begin
          ack_hit    = 1'b1;
          state_next = B_RESP;
        end else if (cnt_expired) begin
          timed_out  = 1'b1;
          state_next = B_RESP;
        end
      end
      B_RESP: begin
        state_next = B_IDLE;
      end
      default: begin
        state_next = B_IDLE;
      end
    endcase
  end

  // Registered outputs, derived from the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q    <= '0;
      mem_cyc  <= 1'b0;
      mem_stb  <= 1'b0;
      bus_full <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      rdata    <= '0;
    end else begin
      if (take_req) begin
        req_q.we  <= !req_read;
        req_q.adr <= req_addr;
        req_q.dat <= req_wdata;
        req_q.sel <= req_sel;
      end
      mem_cyc  <= (state_next == B_REQ);
      mem_stb  <= (state_next == B_REQ);
      bus_full <= (state_next != B_IDLE);
      done     <= (state_next == B_RESP);
      error    <= timed_out;
      if (!req_q.we) begin
        if (ack_hit) begin
          rdata <= mem_dat_i;
        end else if (timed_out) begin
          rdata <= '0;
        end
      end
    end
  end

  assign mem_we    = req_q.we;
  assign mem_adr   = req_q.adr;
  assign mem_dat_o = req_q.dat;
  assign mem_sel   = req_q.sel;

endmodule

// File: tb/tb_bus_interface.sv
// Bench for bus_interface: transaction-timeline model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_bus_interface;

  localparam int T = 16;

  logic        clk;
  logic        rst;
  logic        req_read;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_sel;
  logic        bus_full;
  logic [31:0] rdata;
  logic        done;
  logic        error;
  logic        mem_cyc;
  logic        mem_stb;
  logic        mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_adr;
  logic [31:0] mem_dat_o;
  logic [31:0] mem_dat_i;
  logic        mem_ack;

  bus_interface #(.TIMEOUT_CYCLES(T)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_read (req_read),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_sel  (req_sel),
    .bus_full (bus_full),
    .rdata    (rdata),
    .done     (done),
    .error    (error),
    .mem_cyc  (mem_cyc),
    .mem_stb  (mem_stb),
    .mem_we   (mem_we),
    .mem_sel  (mem_sel),
    .mem_adr  (mem_adr),
    .mem_dat_o(mem_dat_o),
    .mem_dat_i(mem_dat_i),
    .mem_ack  (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  // Transaction model: m_cyc is the cycle index since acceptance (0 = idle),
  // m_done the cycle carrying the done strobe, m_n the planned slave wait count
  // (m_n >= T means the slave never acknowledges).
  int          m_cyc  = 0;
  int          m_done = 0;
  int          m_n    = 0;
  bit          m_err  = 0;
  bit          m_we   = 0;
  logic [31:0] m_adr  = '0;
  logic [31:0] m_dat  = '0;
  logic [3:0]  m_sel  = '0;
  logic [31:0] m_rdata = '0;
  logic [31:0] ack_data = '0;

  bit          use_fixed  = 0;
  int          fixed_n    = 0;
  logic [31:0] fixed_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick_wait();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) return r % 4;
    else if (r < 8) return T - 1;
    else return T;
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_cyc   = 0;
      m_rdata = '0;
    end else if (m_cyc == 0) begin
      if (req_read || req_write) begin
        m_we   = !req_read;
        m_adr  = req_addr;
        m_dat  = req_wdata;
        m_sel  = req_sel;
        m_n    = use_fixed ? fixed_n : pick_wait();
        m_err  = (m_n >= T);
        m_done = m_err ? T + 1 : m_n + 2;
        m_cyc  = 1;
      end
    end else if (m_cyc == m_done) begin
      m_cyc = 0;
    end else begin
      if (m_cyc + 1 == m_done && !m_we) m_rdata = m_err ? 32'h0 : ack_data;
      m_cyc++;
    end
  endtask

  task automatic drive_slave();
    mem_dat_i = use_fixed ? fixed_data : $urandom;
    if (m_cyc >= 1 && m_cyc < m_done) begin
      mem_ack = (!m_err && m_cyc == m_n + 1);
      if (mem_ack) ack_data = mem_dat_i;
    end else begin
      mem_ack = 1'($urandom % 2);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #2;
    drive_slave();
  endtask

  task automatic set_req(input bit rd, input bit wr, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel);
    req_read  = rd;
    req_write = wr;
    req_addr  = adr;
    req_wdata = dat;
    req_sel   = sel;
  endtask

  task automatic no_req();
    req_read  = 1'b0;
    req_write = 1'b0;
  endtask

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("bus_full", 32'(bus_full), 32'(m_cyc != 0));
      check("mem_cyc", 32'(mem_cyc), 32'(m_cyc >= 1 && m_cyc < m_done));
      check("mem_stb", 32'(mem_stb), 32'(m_cyc >= 1 && m_cyc < m_done));
      check("done", 32'(done), 32'(m_cyc != 0 && m_cyc == m_done));
      check("rdata", rdata, m_rdata);
      if (m_cyc != 0 && m_cyc == m_done) check("error", 32'(error), 32'(m_err));
      if (m_cyc >= 1 && m_cyc < m_done) begin
        check("mem_we", 32'(mem_we), 32'(m_we));
        check("mem_adr", mem_adr, m_adr);
        check("mem_sel", 32'(mem_sel), 32'(m_sel));
        if (m_we) check("mem_dat_o", mem_dat_o, m_dat);
      end
    end
  end

  initial begin
    rst = 1'b1;
    set_req(0, 0, '0, '0, '0);
    mem_ack   = 1'b0;
    mem_dat_i = '0;

    tick();
    chk_en = 1;
    tick();
    rst = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_bus_full", 32'(bus_full), 32'h0);
      check("idle_mem_cyc", 32'(mem_cyc), 32'h0);
      check("idle_rdata", rdata, 32'h0);
      check("idle_done", 32'(done), 32'h0);
    end

    // Zero-wait read.
    use_fixed = 1; fixed_n = 0; fixed_data = 32'hDEADBEEF;
    set_req(1, 0, 32'h100, 32'h0, 4'hF);
    tick(); no_req();
    check("rd0_adr_c1", mem_adr, 32'h100);
    check("rd0_we_c1", 32'(mem_we), 32'h0);
    check("rd0_cyc_c1", 32'(mem_cyc), 32'h1);
    tick();
    check("rd0_done_c2", 32'(done), 32'h1);
    check("rd0_rdata_c2", rdata, 32'hDEADBEEF);
    check("rd0_err_c2", 32'(error), 32'h0);
    tick();
    check("rd0_full_c3", 32'(bus_full), 32'h0);

    // Write with three wait cycles.
    fixed_n = 3; fixed_data = 32'hA5A5A5A5;
    set_req(0, 1, 32'h204, 32'h12345678, 4'b0011);
    tick(); no_req();
    for (int c = 1; c <= 4; c++) begin
      check("wr_we", 32'(mem_we), 32'h1);
      check("wr_dat", mem_dat_o, 32'h12345678);
      check("wr_sel", 32'(mem_sel), 32'h3);
      check("wr_adr", mem_adr, 32'h204);
      tick();
    end
    check("wr_done_c5", 32'(done), 32'h1);
    check("wr_rdata_kept", rdata, 32'hDEADBEEF);
    tick();

    // Simultaneous read and write: read only, write dropped.
    fixed_n = 0; fixed_data = 32'h0BADF00D;
    set_req(1, 1, 32'h300, 32'h55, 4'hF);
    tick(); no_req();
    check("both_we_c1", 32'(mem_we), 32'h0);
    tick();
    check("both_done_c2", 32'(done), 32'h1);
    check("both_rdata_c2", rdata, 32'h0BADF00D);
    for (int c = 3; c <= 6; c++) begin
      tick();
      check("both_no_write", 32'(mem_cyc), 32'h0);
    end

    // Slave never acks: timeout.
    fixed_n = T; fixed_data = 32'h11111111;
    set_req(1, 0, 32'h400, 32'h0, 4'hF);
    tick(); no_req();
    for (int c = 1; c < T; c++) begin
      check("to_cyc", 32'(mem_cyc), 32'h1);
      tick();
    end
    check("to_cyc_last", 32'(mem_cyc), 32'h1);
    tick();
    check("to_done", 32'(done), 32'h1);
    check("to_error", 32'(error), 32'h1);
    check("to_rdata", rdata, 32'h0);
    tick();

    // Ack on the final allowed cycle beats the timeout.
    fixed_n = T - 1; fixed_data = 32'h600D0001;
    set_req(1, 0, 32'h404, 32'h0, 4'hF);
    tick(); no_req();
    for (int c = 1; c < T; c++) tick();
    check("late_cyc_c16", 32'(mem_cyc), 32'h1);
    tick();
    check("late_done", 32'(done), 32'h1);
    check("late_error", 32'(error), 32'h0);
    check("late_rdata", rdata, 32'h600D0001);
    tick();

    // Reset in the middle of a 5-wait read.
    fixed_n = 5; fixed_data = 32'h77777777;
    set_req(1, 0, 32'h500, 32'h0, 4'hF);
    tick(); no_req();
    tick();
    rst = 1'b1;
    tick();
    check("rst_cyc", 32'(mem_cyc), 32'h0);
    check("rst_full", 32'(bus_full), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("rst_no_done", 32'(done), 32'h0);
    end
    fixed_n = 1; fixed_data = 32'h0000C0DE;
    set_req(1, 0, 32'h600, 32'h0, 4'hF);
    tick(); no_req();
    tick(); tick();
    check("post_rst_done", 32'(done), 32'h1);
    check("post_rst_rdata", rdata, 32'h0000C0DE);
    tick();

    // Randomized traffic with occasional resets and spurious acks.
    use_fixed = 0;
    for (int i = 0; i < 4000; i++) begin
      rst = (($urandom % 100) == 0);
      set_req(1'($urandom % 3 == 0), 1'($urandom % 3 == 0), $urandom, $urandom, 4'($urandom));
      tick();
    end
    rst = 1'b0;
    no_req();
    for (int i = 0; i < 2 * T; i++) tick();

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
